// File: rtl/rr_free_list_ckpt.sv
// rr_free_list_ckpt: multi-lane physical register free list with branch
// checkpoints for the rename stage.
// Ports: alloc_req/alloc_ok/alloc_preg hand out free pregs (0-cycle),
// rel_en/rel_preg return committed pregs, ckpt_en/ckpt_id snapshot the
// allocation pointer, rec_en/rec_ckpt_id restore it, free_cnt is the
// registered free count, rec_err flags a restore from an empty slot.
module rr_free_list_ckpt #(
  parameter int P_REGISTERS = 64,
  parameter int L_REGISTERS = 32,
  parameter int C_NUM       = 4,
  parameter int INSTR_COUNT = 2,
  localparam int PW    = $clog2(P_REGISTERS),
  localparam int DEPTH = P_REGISTERS - L_REGISTERS,
  localparam int CW    = (C_NUM > 1) ? $clog2(C_NUM) : 1,
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INSTR_COUNT-1:0]    alloc_req,
  output logic                      alloc_ok,
  output logic [INSTR_COUNT*PW-1:0] alloc_preg,
  input  logic [INSTR_COUNT-1:0]    rel_en,
  input  logic [INSTR_COUNT*PW-1:0] rel_preg,
  input  logic                      ckpt_en,
  input  logic [CW-1:0]             ckpt_id,
  input  logic                      rec_en,
  input  logic [CW-1:0]             rec_ckpt_id,
  output logic [NW-1:0]             free_cnt,
  output logic                      rec_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [NW:0] DEP = (NW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  logic [PW-1:0]    mem [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  logic             head_wrap;
  logic             tail_wrap;
  logic [NW-1:0]    cnt;
  logic [C_NUM-1:0] ck_valid;
  ptr_t             ck_head [C_NUM];
  logic [C_NUM-1:0] ck_wrap;

  // (p + n) mod DEPTH by compare-subtract; n never exceeds DEPTH
  function automatic ptr_t idx_add(input ptr_t p, input logic [NW-1:0] n);
    logic [NW:0] s;
    s = (NW+1)'(p) + (NW+1)'(n);
    if (s >= DEP) s = s - DEP;
    return AW'(s);
  endfunction

  function automatic logic carry(input ptr_t p, input logic [NW-1:0] n);
    return ((NW+1)'(p) + (NW+1)'(n)) >= DEP;
  endfunction

  logic [NW-1:0] nreq;
  logic [NW-1:0] nrel;
  ptr_t          wr_idx [INSTR_COUNT];
  logic [NW:0]   cnt_sum;
  logic [NW:0]   rec_diff;
  logic          rec_hit;
  ptr_t          head_n;
  logic          head_wrap_n;
  ptr_t          tail_n;
  logic          tail_wrap_n;
  logic [NW-1:0] cnt_n;

  always_comb begin
    nreq       = '0;
    nrel       = '0;
    alloc_preg = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      wr_idx[i] = idx_add(tail, nrel);
      if (alloc_req[i]) begin
        alloc_preg[i*PW +: PW] = mem[idx_add(head, nreq)];
        nreq = nreq + NW'(1);
      end
      if (rel_en[i]) nrel = nrel + NW'(1);
    end

    alloc_ok = !rec_en && (nreq <= cnt);
    cnt_sum  = {1'b0, cnt}
             - (alloc_ok ? {1'b0, nreq} : '0)
             + {1'b0, nrel};

    tail_n      = idx_add(tail, nrel);
    tail_wrap_n = tail_wrap ^ carry(tail, nrel);

    // Wrap bits separate "pointers equal, empty" from
    // "pointers equal, full" when rebuilding cnt.
    if (tail_wrap_n == ck_wrap[rec_ckpt_id])
      rec_diff = (NW+1)'(tail_n) - (NW+1)'(ck_head[rec_ckpt_id]);
    else
      rec_diff = (NW+1)'(tail_n) + DEP
               - (NW+1)'(ck_head[rec_ckpt_id]);

    rec_hit     = rec_en && ck_valid[rec_ckpt_id];
    head_n      = head;
    head_wrap_n = head_wrap;
    cnt_n       = (cnt_sum > DEP) ? NW'(DEP) : NW'(cnt_sum);

    if (alloc_ok) begin
      head_n      = idx_add(head, nreq);
      head_wrap_n = head_wrap ^ carry(head, nreq);
    end
    if (rec_hit) begin
      head_n      = ck_head[rec_ckpt_id];
      head_wrap_n = ck_wrap[rec_ckpt_id];
      cnt_n       = (rec_diff > DEP) ? NW'(DEP) : NW'(rec_diff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PW'(L_REGISTERS + i);
      head      <= '0;
      tail      <= '0;
      head_wrap <= 1'b0;
      // full list: tail sits one lap ahead of head
      tail_wrap <= 1'b1;
      cnt       <= NW'(DEPTH);
      ck_valid  <= '0;
      ck_wrap   <= '0;
      for (int c = 0; c < C_NUM; c++)
        ck_head[c] <= '0;
      rec_err   <= 1'b0;
    end else begin
      for (int i = 0; i < INSTR_COUNT; i++)
        if (rel_en[i])
          mem[wr_idx[i]] <= rel_preg[i*PW +: PW];
      head      <= head_n;
      head_wrap <= head_wrap_n;
      tail      <= tail_n;
      tail_wrap <= tail_wrap_n;
      cnt       <= cnt_n;
      rec_err   <= rec_en && !ck_valid[rec_ckpt_id];
      if (ckpt_en && !rec_en) begin
        ck_valid[ckpt_id] <= 1'b1;
        ck_head[ckpt_id]  <= head_n;
        ck_wrap[ckpt_id]  <= head_wrap_n;
      end
    end
  end

  assign free_cnt = cnt;

  rel_overflow: assert property (
    @(posedge clk) disable iff (rst) cnt_sum <= DEP
  );

endmodule

// File: tb/tb_rr_free_list_ckpt.sv
// tb_rr_free_list_ckpt: scoreboard bench for rr_free_list_ckpt.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_rr_free_list_ckpt;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  alloc_req = '0;
  logic        alloc_ok;
  logic [11:0] alloc_preg;
  logic [1:0]  rel_en = '0;
  logic [11:0] rel_preg = '0;
  logic        ckpt_en = 1'b0;
  logic [1:0]  ckpt_id = '0;
  logic        rec_en = 1'b0;
  logic [1:0]  rec_ckpt_id = '0;
  logic [5:0]  free_cnt;
  logic        rec_err;

  rr_free_list_ckpt dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_preg(alloc_preg),
    .rel_en(rel_en), .rel_preg(rel_preg),
    .ckpt_en(ckpt_en), .ckpt_id(ckpt_id),
    .rec_en(rec_en), .rec_ckpt_id(rec_ckpt_id),
    .free_cnt(free_cnt), .rec_err(rec_err)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int seq; } ent_t;
  typedef struct {
    logic [1:0] req;
    int ok; int p[2]; int cnt; int err;
    bit hand; int h_ok; int h_p[2]; int h_cnt; int h_err;
  } exp_t;

  int   free_q[$];
  ent_t rob_q[$];
  exp_t exp_q[$];
  int   seq;
  bit   mk_valid[4];
  int   mk_mark[4];
  bit   usable[4];
  bit   err_pend;
  bit   held[64];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   lane;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("alloc_ok", int'(alloc_ok), e.ok);
      chk("free_cnt", int'(free_cnt), e.cnt);
      chk("rec_err", int'(rec_err), e.err);
      chk("cnt_bound", int'(free_cnt <= 6'd32), 1);
      for (int i = 0; i < 2; i++) begin
        lane = int'(alloc_preg[i*6 +: 6]);
        if (!e.req[i]) chk("idle_lane", lane, 0);
        else if (e.ok != 0) begin
          chk("alloc_preg", lane, e.p[i]);
          chk("held_twice", int'(held[lane]), 0);
        end
        if (e.hand && e.req[i] && e.h_ok != 0)
          chk("hand_preg", lane, e.h_p[i]);
      end
      for (int i = 0; i < 2; i++)
        if (e.req[i] && alloc_ok)
          held[alloc_preg[i*6 +: 6]] = 1'b1;
      if (e.hand) begin
        chk("hand_ok", int'(alloc_ok), e.h_ok);
        chk("hand_cnt", int'(free_cnt), e.h_cnt);
        chk("hand_err", int'(rec_err), e.h_err);
      end
    end
  end

  task automatic model_clear();
    free_q.delete();
    rob_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    for (int i = 0; i < 64; i++) held[i] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mk_valid[c] = 1'b0;
      usable[c]   = 1'b0;
      mk_mark[c]  = 0;
    end
    seq      = 0;
    err_pend = 1'b0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle.
  task automatic do_reset();
    alloc_req = '0; rel_en = '0; ckpt_en = 0; rec_en = 0;
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("rst_free_cnt", int'(free_cnt), 32);
    chk("rst_rec_err", int'(rec_err), 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step(
    input logic [1:0] req, input logic [1:0] rel,
    input int r0, input int r1,
    input bit ck, input int ckid,
    input bit rec, input int recid,
    input bit hand, input int h_ok,
    input int h_p0, input int h_p1,
    input int h_cnt, input int h_err
  );
    exp_t e;
    int   k;
    int   nreq;
    ent_t t;
    alloc_req   = req;
    rel_en      = rel;
    rel_preg    = {6'(r1), 6'(r0)};
    ckpt_en     = ck;
    ckpt_id     = 2'(ckid);
    rec_en      = rec;
    rec_ckpt_id = 2'(recid);
    nreq = int'(req[0]) + int'(req[1]);
    e.req = req;
    e.ok  = int'(!rec && nreq <= free_q.size());
    e.cnt = free_q.size();
    e.err = int'(err_pend);
    e.p   = '{0, 0};
    k = 0;
    for (int i = 0; i < 2; i++)
      if (req[i]) begin
        if (k < free_q.size()) e.p[i] = free_q[k];
        k++;
      end
    e.hand = hand; e.h_ok = h_ok;
    e.h_p = '{h_p0, h_p1};
    e.h_cnt = h_cnt; e.h_err = h_err;
    exp_q.push_back(e);
    if (e.ok != 0)
      for (int j = 0; j < nreq; j++) begin
        t.p = free_q.pop_front();
        t.seq = seq++;
        rob_q.push_back(t);
      end
    if (rec) begin
      if (mk_valid[recid]) begin
        while (rob_q.size() > 0 &&
               rob_q[rob_q.size()-1].seq >= mk_mark[recid]) begin
          t = rob_q.pop_back();
          free_q.push_front(t.p);
          held[t.p] = 1'b0;
        end
        for (int c = 0; c < 4; c++)
          if (mk_mark[c] > mk_mark[recid]) usable[c] = 1'b0;
      end
      err_pend = !mk_valid[recid];
    end else begin
      err_pend = 1'b0;
      if (ck) begin
        mk_valid[ckid] = 1'b1;
        usable[ckid]   = 1'b1;
        mk_mark[ckid]  = seq;
      end
    end
    if (rel[0]) begin free_q.push_back(r0); held[r0] = 1'b0; end
    if (rel[1]) begin free_q.push_back(r1); held[r1] = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #6;
    do_reset();
    // drain the list two at a time
    for (int i = 0; i < 16; i++)
      step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,
           1, 1, 32 + 2*i, 33 + 2*i, 32 - 2*i, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // release with no bypass
    step(2'b01, 2'b11, 5, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 5, 9, 2, 0);
    // single entry: pair refused, single lane served
    step(2'b00, 2'b01, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 1, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    // checkpoint and recovery
    do_reset();
    step(2'b11, 2'b00, 0, 0, 1, 1, 0, 0, 1, 1, 32, 33, 32, 0);
    for (int i = 0; i < 3; i++)
      step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,
           1, 1, 34 + 2*i, 35 + 2*i, 30 - 2*i, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 24, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 34, 0, 30, 0);
    // recovery from a never-written slot
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 29, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 29, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 29, 0);

    // random traffic with 1% flushes
    do_reset();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      logic [1:0] req;
      logic [1:0] rel;
      int r[2];
      bit ck;
      bit rec;
      int ckid;
      int recid;
      int minmark;
      int ncom;
      int nrel;
      req = 2'($urandom);
      ck = 0; rec = 0; ckid = 0; recid = 0;
      if ($urandom_range(19) == 0) usable[$urandom_range(3)] = 1'b0;
      if ($urandom_range(99) == 0) begin
        recid = $urandom_range(3);
        rec = 1'b1;
        if (mk_valid[recid] && !usable[recid]) rec = 1'b0;
      end
      if (!rec && $urandom_range(9) == 0) begin
        ck = 1'b1;
        ckid = $urandom_range(3);
      end
      minmark = 32'h7fff_ffff;
      for (int c = 0; c < 4; c++)
        if (usable[c] && mk_mark[c] < minmark) minmark = mk_mark[c];
      ncom = 0;
      while (ncom < 2 && ncom < rob_q.size() &&
             rob_q[ncom].seq < minmark) ncom++;
      rel = 2'($urandom);
      r = '{0, 0};
      nrel = 0;
      for (int i = 0; i < 2; i++)
        if (rel[i]) begin
          if (nrel < ncom) begin
            r[i] = rob_q[nrel].p;
            nrel++;
          end else rel[i] = 1'b0;
        end
      for (int j = 0; j < nrel; j++) void'(rob_q.pop_front());
      step(req, rel, r[0], r[1], ck, ckid, rec, recid,
           0, 0, 0, 0, 0, 0);
    end
    alloc_req = '0; rel_en = '0; ckpt_en = 0; rec_en = 0;
    repeat (3) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
